// File: rtl/fp32_vec_accum_pkg.sv
// Shared types and FP32 constants for the vector
// accumulation controller.
package fp32_vec_accum_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_vec_accum.sv
// Serial FP32 reduction controller: issues one element per
// partial sum to an external pipelined add/sub unit.
module fp32_vec_accum
  import fp32_vec_accum_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             mode_sub,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  output logic             add_sub,
  input  logic [31:0]      add_y,
  input  logic             add_ovf,
  output logic             out_valid,
  output logic [31:0]      out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  localparam int WC_W =
    (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [WC_W-1:0] WC_INIT =
    WC_W'(ADD_LAT - 1);

  state_t            r_state;
  logic [31:0]       r_acc;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_ovf;
  logic              r_mode;
  logic [WC_W-1:0]   r_wcnt;

  logic              w_issue;
  logic              w_done;

  assign w_issue = (r_state == ISSUE);
  assign w_done  = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= FP32_POS_ZERO;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_mode  <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc <= FP32_POS_ZERO;
            r_ovf <= 1'b0;
            if (len != '0) begin
              r_cnt   <= len;
              r_mode  <= mode_sub;
              r_state <= ISSUE;
            end else begin
              r_state <= DONE;
            end
          end
        end
        ISSUE: begin
          if (in_valid) begin
            r_wcnt  <= WC_INIT;
            r_cnt   <= r_cnt - LEN_W'(1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // Only the sample taken on the handshake edge lands here.
          if (r_wcnt == '0) begin
            r_acc   <= add_y;
            r_ovf   <= r_ovf | add_ovf;
            r_state <= (r_cnt == '0) ? DONE : ISSUE;
          end else begin
            r_wcnt <= r_wcnt - WC_W'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = w_issue;
  assign add_a     = r_acc;
  assign add_b     = w_issue ? in_data : FP32_POS_ZERO;
  assign add_sub   = r_mode;
  assign out_valid = w_done;
  assign out_data  = w_done ? r_acc : FP32_POS_ZERO;
  assign out_ovf   = w_done & r_ovf;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fp32_vec_accum.sv
// Bench for fp32_vec_accum with a behavioural one-cycle
// FP32 adder stub and an integer-sum reference model.
module tb_fp32_vec_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        mode_sub;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_sub;
  logic [31:0] add_y;
  logic        add_ovf;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_ready;
  logic        busy;

  logic [31:0] ovf_trig;
  logic [31:0] q_el[$];
  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fp32_vec_accum #(.LEN_W(8), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .mode_sub(mode_sub), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .add_y(add_y), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_data(out_data),
    .out_ovf(out_ovf), .out_ready(out_ready),
    .busy(busy)
  );

  function automatic real fp2real(input logic [31:0] x);
    int  e;
    real m;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    while (e > 127) begin m = m * 2.0; e--; end
    while (e < 127) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] real2fp(input real r);
    logic s;
    int   e;
    real  m;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    return {s, 8'(e), 23'($rtoi((m - 1.0) * 8388608.0))};
  endfunction

  always_ff @(posedge clk) begin
    cyc     <= cyc + 1;
    add_y   <= real2fp(add_sub ?
                 fp2real(add_a) - fp2real(add_b) :
                 fp2real(add_a) + fp2real(add_b));
    add_ovf <= (add_b == ovf_trig);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit sub);
    start    = 1'b1;
    len      = 8'(n);
    mode_sub = sub;
    step();
    start    = 1'b0;
  endtask

  task automatic feed(input int gap, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      int t = 0;
      in_valid = 1'b1;
      in_data  = q_el[i];
      while (!in_ready && t < 100) begin step(); t++; end
      if (t >= 100) chk("feed_timeout", 32'(t), 32'(0));
      step();
      in_valid = 1'b0;
      repeat (gap) step();
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!out_valid && t < 2000) begin step(); t++; end
    chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_after_accept", {30'b0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; len = '0; mode_sub = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    ovf_trig = 32'hFFFF_FFFF;
    repeat (2) step();
    chk("rst_ctrl",
        {27'b0, out_valid, busy, in_ready, out_ovf, add_sub},
        32'd0);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    step();

    // 1+2+3 with in_valid effectively held high
    q_el = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    do_start(3, 1'b0);
    t0 = cyc;
    feed(0, 3);
    wait_done();
    chk("sum_latency", 32'(cyc - t0), 32'd6);
    chk("sum_data", out_data, 32'h40C0_0000);
    chk("sum_ovf", 32'(out_ovf), 32'd0);
    accept();

    q_el = '{32'h3F80_0000, 32'h4000_0000};
    do_start(2, 1'b1);
    feed(0, 2);
    wait_done();
    chk("sub_data", out_data, 32'hC040_0000);
    accept();

    q_el = '{32'h3F80_0000, 32'hBF80_0000};
    do_start(2, 1'b0);
    feed(1, 2);
    wait_done();
    chk("cancel_data", out_data, 32'h0);
    accept();

    do_start(0, 1'b0);
    chk("len0_valid", 32'(out_valid), 32'd1);
    chk("len0_data", out_data, 32'h0);
    chk("len0_ovf", 32'(out_ovf), 32'd0);
    accept();

    // gaps, stalled output, start held while busy
    q_el = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    do_start(3, 1'b0);
    start = 1'b1;
    len   = 8'd0;
    feed(3, 3);
    wait_done();
    repeat (5) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, 32'h40C0_0000);
    end
    start = 1'b0;
    accept();

    // overflow flagged on the 2nd of 4 commits only
    q_el = '{32'h3F80_0000, 32'h40E0_0000,
             32'h4000_0000, 32'h4040_0000};
    ovf_trig = 32'h40E0_0000;
    do_start(4, 1'b0);
    feed(0, 4);
    wait_done();
    chk("ovf_sticky", 32'(out_ovf), 32'd1);
    chk("ovf_data", out_data, 32'h4150_0000);
    accept();
    ovf_trig = 32'hFFFF_FFFF;
    q_el = '{32'h3F80_0000};
    do_start(1, 1'b0);
    feed(0, 1);
    wait_done();
    chk("ovf_cleared", 32'(out_ovf), 32'd0);
    accept();

    // async reset while the second partial sum is in flight
    q_el = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
    do_start(3, 1'b0);
    feed(0, 2);
    rst = 1'b1;
    #1;
    chk("arst_ctrl", {29'b0, out_valid, busy, in_ready}, 32'd0);
    chk("arst_acc", add_a, 32'h0);
    step();
    rst = 1'b0;
    step();
    q_el = '{32'h3F00_0000};
    do_start(1, 1'b0);
    feed(0, 1);
    wait_done();
    chk("post_rst_data", out_data, 32'h3F00_0000);
    accept();

    // maximum length must not wrap the counter
    q_el = {};
    repeat (255) q_el.push_back(32'h3F80_0000);
    do_start(255, 1'b0);
    feed(0, 255);
    wait_done();
    chk("maxlen_data", out_data, 32'h437F_0000);
    accept();

    for (int k = 0; k < 20; k++) begin
      int  n;
      int  gap;
      int  sum;
      int  tv;
      bit  sub;
      bit  eovf;
      n    = int'($urandom_range(8, 1));
      gap  = int'($urandom_range(2, 0));
      sub  = 1'($urandom_range(1, 0));
      tv   = int'($urandom_range(16, 0)) - 8;
      ovf_trig = real2fp(real'(tv));
      sum  = 0;
      eovf = 1'b0;
      q_el = {};
      for (int i = 0; i < n; i++) begin
        int v;
        v = int'($urandom_range(16, 0)) - 8;
        q_el.push_back(real2fp(real'(v)));
        sum  = sub ? sum - v : sum + v;
        eovf = eovf | (v == tv);
      end
      do_start(n, sub);
      feed(gap, n);
      wait_done();
      chk("rand_data", out_data, real2fp(real'(sum)));
      chk("rand_ovf", 32'(out_ovf), 32'(eovf));
      accept();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
